// File: rtl/dmem_if.sv
// Load/store handshake between the MIPS MEM stage (master) and the data memory (slave).
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        stall;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, busy, stall, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, busy, stall, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the pipelined MIPS core's MEM stage.
// Optional misaligned-access rejection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam bit LAT1  = (LATENCY == 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ack_q;
  logic             busy_q;
  logic             err_q;
  logic [31:0]      rdata_q;

  logic             we_q;
  logic [AW-1:0]    idx_q;
  logic [31:0]      wdata_q;
  logic             mis_q;

  logic [31:0]      mem [DEPTH];

  logic             mis_in;
  logic             sel_we;
  logic [AW-1:0]    sel_idx;
  logic [31:0]      sel_wdata;
  logic             sel_mis;
  logic             commit;
  logic             unused_addr_bits;

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis_in = (bus.addr[1:0] != 2'b00);
`else
  assign mis_in = 1'b0;
`endif

  assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};

  // With a one-cycle latency the RESP entry coincides with the accept edge,
  // so the access must use the live inputs rather than the latched copy.
  always_comb begin
    sel_we    = we_q;
    sel_idx   = idx_q;
    sel_wdata = wdata_q;
    sel_mis   = mis_q;
    if (LAT1 && state == IDLE) begin
      sel_we    = bus.we;
      sel_idx   = bus.addr[AW+1:2];
      sel_wdata = bus.wdata;
      sel_mis   = mis_in;
    end
  end

  always_comb begin
    if (LAT1) commit = (state == IDLE) && bus.req;
    else      commit = (state == WAIT) && (cnt == '0);
  end

  // Accept stage: capture the request fields
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req) begin
      we_q    <= bus.we;
      idx_q   <= bus.addr[AW+1:2];
      wdata_q <= bus.wdata;
      mis_q   <= mis_in;
    end
  end

  // Control FSM and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            busy_q <= 1'b1;
            if (LAT1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
      if (commit) begin
        ack_q <= 1'b1;
        err_q <= sel_mis;
        if (!sel_we && !sel_mis) rdata_q <= mem[sel_idx];
      end
    end
  end

  // Commit stage: stores land on RESP entry; reset abandons them
  always_ff @(posedge clk) begin
    if (!reset && commit && sel_we && !sel_mis) mem[sel_idx] <= sel_wdata;
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;
  assign bus.stall = bus.req & ~ack_q;

endmodule
